// File: rtl/spi_pkg.sv
// Shared SPI definitions: data width, capture counter width, FSM state
// encoding, and a helper that picks the first bit on the wire for either
// bit order.
package spi_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic first_bit(input logic [DATA_W-1:0] d, input bit msb_first);
    return msb_first ? d[DATA_W-1] : d[0];
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 byte shifter. Sends one byte per chip-select assertion and
// captures the byte returned on MISO. SCLK itself comes from a separate
// clock divider; this block only sees the divider's ready flag and its
// rise/fall flags, which arrive one i_clk cycle ahead of the SCLK edge.
//
// Ports
//   i_clk, i_rst_n            system clock, synchronous active-low reset
//   i_tx_data, i_tx_valid     byte to send and its request
//   o_tx_ready                byte can be accepted this cycle
//   o_rx_data, o_rx_valid     last received byte, one-cycle update pulse
//   o_busy                    transfer in progress
//   i_div_ready/rise/fall     divider status and SCLK edge flags
//   o_div_start_n             active-low divider start pulse
//   i_miso, o_mosi, o_cs_n    SPI pins
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | cs_n high, mosi low, waiting for a byte
// ST_START | one cycle, kicks the divider (o_div_start_n low)
// ST_SHIFT | cs_n low, capture on rise flags, advance mosi on falls
// ST_DONE  | one cycle, publish rx byte, cs_n high, mosi low
module spi_shifter
  import spi_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy,
  input  logic              i_div_ready,
  input  logic              i_div_rise,
  input  logic              i_div_fall,
  output logic              o_div_start_n,
  input  logic              i_miso,
  output logic              o_mosi,
  output logic              o_cs_n
);

  logic [1:0]        state_q,    state_d;
  logic [DATA_W-1:0] tx_sr_q,    tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q,    rx_sr_d;
  logic [DATA_W-1:0] rx_data_q,  rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              mosi_q,     mosi_d;
  logic              cap_pend_q, cap_pend_d;
  logic              cap_full_q, cap_full_d;
  logic [CNT_W-1:0]  cap_cnt_q,  cap_cnt_d;
  logic [CNT_W-1:0]  fall_cnt_q, fall_cnt_d;
  logic              accept;

  // Gated by reset so nothing is offered while the block is held in reset.
  assign o_tx_ready = i_rst_n && (state_q == ST_IDLE) && i_div_ready;
  assign accept     = i_tx_valid && o_tx_ready;

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    mosi_d     = mosi_q;
    cap_pend_d = 1'b0;
    cap_full_d = cap_full_q;
    cap_cnt_d  = cap_cnt_q;
    fall_cnt_d = fall_cnt_q;
    case (state_q)
      ST_IDLE: begin
        mosi_d = 1'b0;
        if (accept) begin
          tx_sr_d    = i_tx_data;
          mosi_d     = first_bit(i_tx_data, MSB_FIRST);
          rx_sr_d    = '0;
          cap_cnt_d  = '0;
          fall_cnt_d = '0;
          cap_full_d = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: state_d = ST_SHIFT;
      ST_SHIFT: begin
        // Rise flag leads SCLK by one cycle, so MISO is sampled one cycle later.
        cap_pend_d = i_div_rise;
        if (cap_pend_q) begin
          rx_sr_d   = MSB_FIRST ? {rx_sr_q[DATA_W-2:0], i_miso}
                                : {i_miso, rx_sr_q[DATA_W-1:1]};
          cap_cnt_d = cap_cnt_q + 1'b1;
          if (cap_cnt_q == '1) cap_full_d = 1'b1;
        end
        // The last bit must stay on MOSI through the 8th falling edge.
        if (i_div_fall && (fall_cnt_q != '1)) begin
          tx_sr_d    = MSB_FIRST ? (tx_sr_q << 1) : (tx_sr_q >> 1);
          mosi_d     = MSB_FIRST ? tx_sr_q[DATA_W-2] : tx_sr_q[1];
          fall_cnt_d = fall_cnt_q + 1'b1;
        end
        if (cap_full_q && i_div_ready) begin
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          mosi_d     = 1'b0;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        mosi_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      mosi_q     <= 1'b0;
      cap_pend_q <= 1'b0;
      cap_full_q <= 1'b0;
      cap_cnt_q  <= '0;
      fall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      mosi_q     <= mosi_d;
      cap_pend_q <= cap_pend_d;
      cap_full_q <= cap_full_d;
      cap_cnt_q  <= cap_cnt_d;
      fall_cnt_q <= fall_cnt_d;
    end
  end

  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_mosi        = mosi_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_div_start_n = (state_q != ST_START);
  assign o_cs_n        = !((state_q == ST_START) || (state_q == ST_SHIFT));

endmodule

// File: tb/tb_spi_shifter.sv
// Bench for spi_shifter: an MSB-first and an LSB-first instance share the
// stimulus; a behavioural clock divider supplies ready/rise/fall flags.
module tb_spi_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tx_valid;
  logic [7:0] tx_data;
  logic       div_ready, div_rise, div_fall;
  logic       loop_en, miso_fix;

  logic       tx_ready_m, rx_valid_m, busy_m, div_start_n_m, mosi_m, cs_n_m, miso_m;
  logic [7:0] rx_data_m;
  logic       tx_ready_l, rx_valid_l, busy_l, div_start_n_l, mosi_l, cs_n_l, miso_l;
  logic [7:0] rx_data_l;

  assign miso_m = loop_en ? mosi_m : miso_fix;
  assign miso_l = loop_en ? mosi_l : miso_fix;

  spi_shifter #(.MSB_FIRST(1'b1)) dut_m (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready_m), .o_rx_data(rx_data_m), .o_rx_valid(rx_valid_m),
    .o_busy(busy_m), .i_div_ready(div_ready), .i_div_rise(div_rise),
    .i_div_fall(div_fall), .o_div_start_n(div_start_n_m), .i_miso(miso_m),
    .o_mosi(mosi_m), .o_cs_n(cs_n_m));

  spi_shifter #(.MSB_FIRST(1'b0)) dut_l (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready_l), .o_rx_data(rx_data_l), .o_rx_valid(rx_valid_l),
    .o_busy(busy_l), .i_div_ready(div_ready), .i_div_rise(div_rise),
    .i_div_fall(div_fall), .o_div_start_n(div_start_n_l), .i_miso(miso_l),
    .o_mosi(mosi_l), .o_cs_n(cs_n_l));

  // Behavioural divider: 8 SCLK periods of div_n cycles, rise flag one
  // cycle before SCLK goes high (mid period), fall flag at period end.
  int div_n, dcnt;
  bit drun;
  always @(negedge clk) begin
    div_rise = 1'b0;
    div_fall = 1'b0;
    if (!rst_n) begin
      drun = 1'b0;
      div_ready = 1'b1;
    end else begin
      if (drun) begin
        if (dcnt == 8 * div_n) begin
          drun = 1'b0;
          div_ready = 1'b1;
        end else begin
          div_rise = ((dcnt % div_n) == (div_n / 2 - 1));
          div_fall = ((dcnt % div_n) == (div_n - 1));
          dcnt++;
        end
      end
      if (!div_start_n_m && !drun) begin
        drun = 1'b1;
        dcnt = 0;
        div_ready = 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] bits_m, bits_l, rx_l, e, g;
  int  nbits, cs_hi_wait;
  bit  acc_ok, done_ok, cs_err, cs_done, mosi_done, mosi_last;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  // Stimulus/monitor only: drives one transfer and records what was seen.
  task automatic run_xfer(input logic [7:0] d, input logic [7:0] exp_rx,
                          input logic [7:0] nxt, input bit hold, input int poke);
    int cyc;
    int w;
    acc_ok = 0; done_ok = 0; cs_err = 0; nbits = 0; bits_m = '0; bits_l = '0;
    cs_hi_wait = 0; mosi_last = 0; cs_done = 0; mosi_done = 1;
    tx_data = d;
    tx_valid = 1'b1;
    w = 0;
    while (!acc_ok && w < 100) begin
      if (cs_n_m) cs_hi_wait++;
      if (tx_ready_m) acc_ok = 1;
      @(posedge clk); #2;
      w++;
    end
    if (!acc_ok) begin
      tx_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp_rx);
    tx_data = nxt;
    tx_valid = hold;
    cyc = 0;
    while (!done_ok && cyc < 200) begin
      if (poke > 0 && cyc == poke) begin tx_data = 8'hFF; tx_valid = 1'b1; end
      if (poke > 0 && cyc == poke + 1) tx_valid = 1'b0;
      if (rx_valid_m) begin
        done_ok = 1;
        got_q.push_back(rx_data_m);
        rx_l = rx_data_l;
        cs_done = cs_n_m;
        mosi_done = mosi_m;
      end else begin
        if (cs_n_m) cs_err = 1;
        if (div_rise) begin
          bits_m = {bits_m[6:0], mosi_m};
          bits_l = {bits_l[6:0], mosi_l};
          nbits++;
        end
        mosi_last = mosi_m;
        @(posedge clk); #2;
        cyc++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (cs_n_m !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n got %b want 1", cs_n_m); end
    n_checks++; if (mosi_m !== 1'b0) begin n_fail++; $display("FAIL rst_mosi got %b want 0", mosi_m); end
    n_checks++; if (div_start_n_m !== 1'b1) begin n_fail++; $display("FAIL rst_div_start_n got %b want 1", div_start_n_m); end
    n_checks++; if (rx_valid_m !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid got %b want 0", rx_valid_m); end
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy_m); end
    n_checks++; if (rx_data_m !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data got %h want 00", rx_data_m); end
    n_checks++; if (tx_ready_m !== 1'b0) begin n_fail++; $display("FAIL rst_tx_ready got %b want 0", tx_ready_m); end
    n_checks++; if ({tx_ready_l, busy_l, cs_n_l, div_start_n_l} !== 4'b0011) begin
      n_fail++; $display("FAIL rst_lsb_outs got %b want 0011", {tx_ready_l, busy_l, cs_n_l, div_start_n_l}); end
    rst_n = 1'b1;
    @(posedge clk); #2;
    n_checks++; if (tx_ready_m !== 1'b1) begin n_fail++; $display("FAIL idle_tx_ready got %b want 1", tx_ready_m); end
    n_checks++; if (cs_n_m !== 1'b1 || mosi_m !== 1'b0) begin
      n_fail++; $display("FAIL idle_pins got cs_n=%b mosi=%b want 1 0", cs_n_m, mosi_m); end
  endtask

  task automatic test_loopback_a5;
    int extra;
    div_n = 4; loop_en = 1'b1;
    run_xfer(8'hA5, 8'hA5, 8'h5A, 1'b0, 0);
    n_checks++; if (!(acc_ok && done_ok)) begin n_fail++; $display("FAIL a5_timeout got acc=%0d done=%0d want 1 1", acc_ok, done_ok); end
    n_checks++; if (nbits !== 8) begin n_fail++; $display("FAIL a5_nbits got %0d want 8", nbits); end
    n_checks++; if (bits_m !== 8'hA5) begin n_fail++; $display("FAIL a5_mosi_seq got %h want a5", bits_m); end
    n_checks++; if (mosi_last !== 1'b1) begin n_fail++; $display("FAIL a5_mosi_after_8th_fall got %b want 1", mosi_last); end
    if (exp_q.size() == 0 || got_q.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL a5_sb_empty got %0d want 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL a5_rx_data got %h want %h", g, e); end
    end
    n_checks++; if (cs_err) begin n_fail++; $display("FAIL a5_cs_low got high want low"); end
    n_checks++; if (cs_done !== 1'b1 || mosi_done !== 1'b0) begin
      n_fail++; $display("FAIL a5_done_pins got cs_n=%b mosi=%b want 1 0", cs_done, mosi_done); end
    extra = 0;
    repeat (6) begin @(posedge clk); #2; if (rx_valid_m) extra++; end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL a5_one_pulse got %0d extra want 0", extra); end
    n_checks++; if (rx_data_m !== 8'hA5) begin n_fail++; $display("FAIL a5_rx_hold got %h want a5", rx_data_m); end
  endtask

  task automatic test_tied_one;
    div_n = 2; loop_en = 1'b0; miso_fix = 1'b1;
    run_xfer(8'h3C, 8'hFF, 8'hC3, 1'b0, 0);
    n_checks++; if (!(acc_ok && done_ok)) begin n_fail++; $display("FAIL t1_timeout got acc=%0d done=%0d want 1 1", acc_ok, done_ok); end
    n_checks++; if (bits_m !== 8'h3C) begin n_fail++; $display("FAIL t1_mosi_seq got %h want 3c", bits_m); end
    if (exp_q.size() == 0 || got_q.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL t1_sb_empty got %0d want 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL t1_rx_data got %h want %h", g, e); end
    end
    n_checks++; if (rx_l !== 8'hFF) begin n_fail++; $display("FAIL t1_rx_lsb got %h want ff", rx_l); end
    n_checks++; if (cs_err) begin n_fail++; $display("FAIL t1_cs_low got high want low"); end
    n_checks++; if (cs_done !== 1'b1) begin n_fail++; $display("FAIL t1_cs_done got %b want 1", cs_done); end
    @(posedge clk); #2;
  endtask

  task automatic test_back_to_back;
    div_n = 4; loop_en = 1'b1;
    run_xfer(8'h01, 8'h01, 8'h80, 1'b1, 0);
    n_checks++; if (!(acc_ok && done_ok)) begin n_fail++; $display("FAIL b2b_first_timeout got acc=%0d done=%0d want 1 1", acc_ok, done_ok); end
    run_xfer(8'h80, 8'h80, 8'h00, 1'b0, 0);
    n_checks++; if (!(acc_ok && done_ok)) begin n_fail++; $display("FAIL b2b_second_timeout got acc=%0d done=%0d want 1 1", acc_ok, done_ok); end
    n_checks++; if (cs_hi_wait < 2) begin n_fail++; $display("FAIL b2b_cs_gap got %0d want >=2", cs_hi_wait); end
    n_checks++; if (bits_m !== 8'h80) begin n_fail++; $display("FAIL b2b_mosi_seq got %h want 80", bits_m); end
    for (int k = 0; k < 2; k++) begin
      if (exp_q.size() == 0 || got_q.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL b2b_sb_empty got %0d want 2", k);
      end else begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_rx_data got %h want %h", g, e); end
      end
    end
    @(posedge clk); #2;
  endtask

  task automatic test_ignore_in_shift;
    int busy_seen;
    div_n = 4; loop_en = 1'b1;
    run_xfer(8'h96, 8'h96, 8'h00, 1'b0, 6);
    n_checks++; if (!(acc_ok && done_ok)) begin n_fail++; $display("FAIL ign_timeout got acc=%0d done=%0d want 1 1", acc_ok, done_ok); end
    n_checks++; if (bits_m !== 8'h96) begin n_fail++; $display("FAIL ign_mosi_seq got %h want 96", bits_m); end
    if (exp_q.size() == 0 || got_q.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL ign_sb_empty got %0d want 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL ign_rx_data got %h want %h", g, e); end
    end
    busy_seen = 0;
    repeat (20) begin @(posedge clk); #2; if (busy_m && !rx_valid_m) busy_seen++; end
    n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL ign_no_extra_xfer got %0d busy cycles want 0", busy_seen); end
  endtask

  task automatic test_lsb_first;
    logic [7:0] want;
    div_n = 4; loop_en = 1'b1;
    want = rev8(8'h01);
    run_xfer(8'h01, 8'h01, 8'h00, 1'b0, 0);
    n_checks++; if (!(acc_ok && done_ok)) begin n_fail++; $display("FAIL lsb_timeout got acc=%0d done=%0d want 1 1", acc_ok, done_ok); end
    n_checks++; if (bits_l[7] !== 1'b1) begin n_fail++; $display("FAIL lsb_first_bit got %b want 1", bits_l[7]); end
    n_checks++; if (bits_l !== want) begin n_fail++; $display("FAIL lsb_mosi_seq got %h want %h", bits_l, want); end
    n_checks++; if (rx_l !== 8'h01) begin n_fail++; $display("FAIL lsb_rx_data got %h want 01", rx_l); end
    if (exp_q.size() == 0 || got_q.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL lsb_sb_empty got %0d want 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL lsb_msb_inst_rx got %h want %h", g, e); end
    end
    @(posedge clk); #2;
  endtask

  task automatic test_reset_mid;
    int w, rises, pulses, cs_low;
    bit acc;
    div_n = 4; loop_en = 1'b1;
    tx_data = 8'hC3; tx_valid = 1'b1;
    acc = 0; w = 0;
    while (!acc && w < 50) begin
      if (tx_ready_m) acc = 1;
      @(posedge clk); #2;
      w++;
    end
    tx_valid = 1'b0;
    n_checks++; if (!acc) begin n_fail++; $display("FAIL rmid_accept_timeout got 0 want 1"); end
    rises = 0; w = 0;
    while (rises < 3 && w < 100) begin
      if (div_rise) rises++;
      @(posedge clk); #2;
      w++;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    n_checks++; if (cs_n_m !== 1'b1) begin n_fail++; $display("FAIL rmid_cs_n got %b want 1", cs_n_m); end
    n_checks++; if (rx_valid_m !== 1'b0 || busy_m !== 1'b0) begin
      n_fail++; $display("FAIL rmid_abort got rx_valid=%b busy=%b want 0 0", rx_valid_m, busy_m); end
    n_checks++; if (rx_data_m !== 8'h00) begin n_fail++; $display("FAIL rmid_rx_data got %h want 00", rx_data_m); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    pulses = 0; cs_low = 0;
    repeat (40) begin
      @(posedge clk); #2;
      if (rx_valid_m) pulses++;
      if (!cs_n_m) cs_low++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rmid_no_rx_valid got %0d want 0", pulses); end
    n_checks++; if (cs_low !== 0) begin n_fail++; $display("FAIL rmid_cs_stays_high got %0d low cycles want 0", cs_low); end
    n_checks++; if (rx_data_m !== 8'h00) begin n_fail++; $display("FAIL rmid_rx_hold got %h want 00", rx_data_m); end
  endtask

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    div_ready = 1'b1; div_rise = 1'b0; div_fall = 1'b0;
    loop_en = 1'b1; miso_fix = 1'b0; div_n = 4; drun = 1'b0; dcnt = 0;
    test_reset;
    test_loopback_a5;
    test_tied_one;
    test_back_to_back;
    test_ignore_in_shift;
    test_lsb_first;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/spi_shifter.md
SPI_SHIFTER -- requirements
Module: spi_shifter

Interface
REQ-001 Parameter MSB_FIRST, default 1, meaning 1 = shift/capture bit 7 first, 0 = bit 0 first.
REQ-002 i_clk  input  1  system clock; all logic on rising edge.
REQ-003 i_rst_n  input  1  synchronous, active-low reset.
REQ-004 i_tx_data  input  8  byte to transmit.
REQ-005 i_tx_valid  input  1  request to send i_tx_data.
REQ-006 o_tx_ready  output  1  shifter can accept a byte this cycle.
REQ-007 o_rx_data  output  8  last received byte, held until the next transfer completes.
REQ-008 o_rx_valid  output  1  one-cycle pulse when o_rx_data is updated.
REQ-009 o_busy  output  1  transfer in progress.
REQ-010 i_div_ready, i_div_rise, i_div_fall  input  1 each  clock-divider ready and edge flags; each edge flag leads its SCLK edge by one i_clk cycle.
REQ-011 o_div_start_n  output  1  active-low start pulse to the clock divider.
REQ-012 i_miso  input  1  serial data from peripheral.
REQ-013 o_mosi  output  1  serial data to peripheral.
REQ-014 o_cs_n  output  1  active-low chip select.

Function
REQ-015 Protocol SHALL be SPI mode 0 (CPOL=0, CPHA=0), 8 bits per transfer, one byte per chip-select assertion.
REQ-016 States SHALL be IDLE, START, SHIFT, DONE.
REQ-017 o_tx_ready SHALL equal (state==IDLE && i_div_ready); a byte is accepted only when i_tx_valid && o_tx_ready.
REQ-018 On accept: load the shift register; o_cs_n=0, o_mosi=first bit, o_busy=1 from the next cycle; go to START.
REQ-019 START SHALL last exactly one cycle with o_div_start_n=0, then go to SHIFT; o_div_start_n SHALL be 1 in every other state.
REQ-020 In SHIFT, each i_div_rise SHALL cause i_miso to be captured in the following cycle into the receive register; the 3-bit capture counter increments per capture.
REQ-021 In SHIFT, i_div_fall pulses 1..7 SHALL advance o_mosi to the next bit; the 8th fall SHALL NOT change o_mosi.
REQ-022 SHIFT SHALL go to DONE when 8 bits are captured and i_div_ready==1.
REQ-023 DONE SHALL last one cycle: o_rx_data updated, o_rx_valid=1, o_cs_n=1, o_mosi=0; next state IDLE.
REQ-024 o_cs_n SHALL stay high for at least two cycles (DONE, IDLE) between consecutive transfers.
REQ-025 i_tx_valid while not in IDLE SHALL be ignored; i_tx_data SHALL NOT be sampled outside the accept cycle.
REQ-026 Edge flags outside SHIFT SHALL be ignored; simultaneous i_div_rise and i_div_fall SHALL both be actioned.
REQ-027 In IDLE o_mosi=0 and o_cs_n=1.
REQ-028 With MSB_FIRST=0 the bit order SHALL be reversed for both transmit and receive.

Reset
REQ-029 While i_rst_n=0: state=IDLE, o_cs_n=1, o_mosi=0, o_div_start_n=1, o_rx_valid=0, o_busy=0, o_rx_data=8'h00, counters=0; o_tx_ready SHALL be 0.
REQ-030 Reset mid-transfer SHALL abort it: no o_rx_valid pulse, o_cs_n=1 on the first cycle after the reset edge.

Structure
REQ-031 State encoding and data width (8) SHALL be localparams in the shared spi_pkg package.
REQ-032 No sub-module; spi_shifter SHALL be instantiated beside clock_divider in the SPI controller top level.

Verification
REQ-033 Divider divisor 4; send 8'hA5 with i_miso looped to o_mosi -> o_mosi sequence 1,0,1,0,0,1,0,1; o_rx_data=8'hA5; exactly one o_rx_valid pulse.
REQ-034 Divisor 2; send 8'h3C with i_miso tied 1 -> o_rx_data=8'hFF; o_cs_n low for the whole transfer, high in DONE.
REQ-035 Back-to-back 8'h01 then 8'h80 with i_tx_valid held -> two transfers; o_cs_n high for at least 2 cycles between them; second byte accepted only after o_tx_ready reasserts.
REQ-036 Assert i_rst_n=0 after 3 captured bits -> o_cs_n=1 next cycle, no o_rx_valid, o_rx_data stays 8'h00.
REQ-037 MSB_FIRST=0; send 8'h01 with loopback -> first o_mosi bit 1, o_rx_data=8'h01.
REQ-038 i_tx_valid pulsed in SHIFT with 8'hFF -> ignored; in-flight byte completes unchanged.
